// File: rtl/axil_cmd_seq_if.sv
// ============================================================================
// Module      : axil_cmd_seq_if
// Description : AXI4-Lite bus bundle between the command sequencer (master)
//               and the interconnect (slave).
//               Ports : none (signal bundle only)
//               Signals: AW (awaddr/awprot/awvalid/awready),
//                        W  (wdata/wstrb/wvalid/wready),
//                        B  (bresp/bvalid/bready),
//                        AR (araddr/arprot/arvalid/arready),
//                        R  (rdata/rresp/rvalid/rready)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axil_cmd_seq_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

`default_nettype wire

// File: rtl/axil_cmd_seq.sv
// ============================================================================
// Module      : axil_cmd_seq
// Description : AXI4-Lite master that walks a small command table and issues
//               WRITE, READ, POLL-until-match and DELAY operations.
//               Ports : M_AXI_aclk / M_AXI_aresetn  clock, async active-low rst
//                       cmd_we/idx/op/addr/data/mask table load port
//                       start                        launch at entry 0
//                       busy/done/error/err_code/err_idx  run status
//                       rd_valid/rd_data             captured read beats
//                       m_axi                        AXI4-Lite master bus
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_cmd_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_CMDS   = 16,
    parameter int POLL_MAX   = 1024,
    parameter int DLY_WIDTH  = 16
) (
    input  wire logic                        M_AXI_aclk,
    input  wire logic                        M_AXI_aresetn,
    input  wire logic                        cmd_we,
    input  wire logic [$clog2(NUM_CMDS)-1:0] cmd_idx,
    input  wire logic [2:0]                  cmd_op,
    input  wire logic [ADDR_WIDTH-1:0]       cmd_addr,
    input  wire logic [DATA_WIDTH-1:0]       cmd_data,
    input  wire logic [DATA_WIDTH-1:0]       cmd_mask,
    input  wire logic                        start,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [1:0]                       err_code,
    output logic [$clog2(NUM_CMDS)-1:0]      err_idx,
    output logic                             rd_valid,
    output logic [DATA_WIDTH-1:0]            rd_data,
    axil_cmd_seq_if.master                   m_axi
);

    localparam int IDX_W = $clog2(NUM_CMDS);
    localparam int ATT_W = $clog2(POLL_MAX + 1);

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_CMDS - 1);
    localparam logic [ATT_W-1:0] C_LAST_ATT = ATT_W'(POLL_MAX - 1);

    localparam logic [2:0] C_OP_WRITE = 3'd1;
    localparam logic [2:0] C_OP_READ  = 3'd2;
    localparam logic [2:0] C_OP_POLL  = 3'd3;
    localparam logic [2:0] C_OP_DELAY = 3'd4;

    localparam logic [1:0] C_ERR_BRESP = 2'b01;
    localparam logic [1:0] C_ERR_RRESP = 2'b10;
    localparam logic [1:0] C_ERR_POLL  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_FETCH = 4'd1,
        S_WADDR = 4'd2,
        S_WRESP = 4'd3,
        S_RADDR = 4'd4,
        S_RDATA = 4'd5,
        S_PCHK  = 4'd6,
        S_DELAY = 4'd7,
        S_FIN   = 4'd8
    } state_t;

    // Command table (not reset; contents survive a sequencer reset)
    logic [2:0]            r_tbl_op   [NUM_CMDS];
    logic [ADDR_WIDTH-1:0] r_tbl_addr [NUM_CMDS];
    logic [DATA_WIDTH-1:0] r_tbl_data [NUM_CMDS];
    logic [DATA_WIDTH-1:0] r_tbl_mask [NUM_CMDS];

    state_t                r_state;
    logic [IDX_W-1:0]      r_pc;
    logic [2:0]            r_op;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [DLY_WIDTH-1:0]  r_cnt;
    logic [ATT_W-1:0]      r_attempt;

    logic                  w_start_ok;
    logic                  w_aw_ok;
    logic                  w_w_ok;
    logic                  w_r_fire;
    state_t                w_adv_state;
    logic [IDX_W-1:0]      w_adv_pc;

    assign m_axi.awprot = 3'b000;
    assign m_axi.arprot = 3'b000;
    assign m_axi.wstrb  = '1;

    // A table write in the same cycle as start takes priority
    assign w_start_ok = start && !cmd_we;

    // Each write channel is finished once its valid is low or being accepted
    assign w_aw_ok = !m_axi.awvalid || m_axi.awready;
    assign w_w_ok  = !m_axi.wvalid  || m_axi.wready;

    // Read data beat; also taken in RADDR when arready and rvalid coincide
    assign w_r_fire = m_axi.rvalid && m_axi.rready &&
                      ((r_state == S_RDATA) ||
                       ((r_state == S_RADDR) && m_axi.arready));

    // Step to the next entry; the last entry acts as an implicit END
    assign w_adv_state = (r_pc == C_LAST_IDX) ? S_FIN : S_FETCH;
    assign w_adv_pc    = (r_pc == C_LAST_IDX) ? r_pc  : r_pc + 1'b1;

    always_ff @(posedge M_AXI_aclk) begin
        if (cmd_we && !busy) begin
            r_tbl_op[cmd_idx]   <= cmd_op;
            r_tbl_addr[cmd_idx] <= cmd_addr;
            r_tbl_data[cmd_idx] <= cmd_data;
            r_tbl_mask[cmd_idx] <= cmd_mask;
        end
    end

    always_ff @(posedge M_AXI_aclk or negedge M_AXI_aresetn) begin
        if (!M_AXI_aresetn) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_op          <= '0;
            r_data        <= '0;
            r_mask        <= '0;
            r_cnt         <= '0;
            r_attempt     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            err_code      <= 2'b00;
            err_idx       <= '0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
            m_axi.awaddr  <= '0;
            m_axi.awvalid <= 1'b0;
            m_axi.wdata   <= '0;
            m_axi.wvalid  <= 1'b0;
            m_axi.bready  <= 1'b0;
            m_axi.araddr  <= '0;
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b0;
        end else begin
            rd_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        err_code <= 2'b00;
                        r_pc     <= '0;
                        r_state  <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    r_op      <= r_tbl_op[r_pc];
                    r_data    <= r_tbl_data[r_pc];
                    r_mask    <= r_tbl_mask[r_pc];
                    r_attempt <= '0;
                    case (r_tbl_op[r_pc])
                        C_OP_WRITE: begin
                            m_axi.awaddr  <= r_tbl_addr[r_pc];
                            m_axi.wdata   <= r_tbl_data[r_pc];
                            m_axi.awvalid <= 1'b1;
                            m_axi.wvalid  <= 1'b1;
                            r_state       <= S_WADDR;
                        end
                        C_OP_READ, C_OP_POLL: begin
                            m_axi.araddr  <= r_tbl_addr[r_pc];
                            m_axi.arvalid <= 1'b1;
                            m_axi.rready  <= 1'b1;
                            r_state       <= S_RADDR;
                        end
                        C_OP_DELAY: begin
                            r_cnt   <= r_tbl_data[r_pc][DLY_WIDTH-1:0];
                            r_state <= S_DELAY;
                        end
                        default: r_state <= S_FIN;
                    endcase
                end

                S_WADDR: begin
                    if (m_axi.awvalid && m_axi.awready) begin
                        m_axi.awvalid <= 1'b0;
                    end
                    if (m_axi.wvalid && m_axi.wready) begin
                        m_axi.wvalid <= 1'b0;
                    end
                    if (w_aw_ok && w_w_ok) begin
                        m_axi.bready <= 1'b1;
                        r_state      <= S_WRESP;
                    end
                end

                S_WRESP: begin
                    if (m_axi.bvalid && m_axi.bready) begin
                        m_axi.bready <= 1'b0;
                        if (m_axi.bresp != 2'b00) begin
                            err_code <= C_ERR_BRESP;
                            r_state  <= S_FIN;
                        end else begin
                            r_pc    <= w_adv_pc;
                            r_state <= w_adv_state;
                        end
                    end
                end

                S_RADDR: begin
                    if (m_axi.arready) begin
                        m_axi.arvalid <= 1'b0;
                        r_state       <= S_RDATA;
                    end
                end

                S_RDATA: begin
                    // Beat completion is handled by the shared capture below
                end

                S_PCHK: begin
                    if ((rd_data & r_mask) == (r_data & r_mask)) begin
                        r_attempt <= '0;
                        r_pc      <= w_adv_pc;
                        r_state   <= w_adv_state;
                    end else if (r_attempt == C_LAST_ATT) begin
                        err_code <= C_ERR_POLL;
                        r_state  <= S_FIN;
                    end else begin
                        r_attempt     <= r_attempt + 1'b1;
                        m_axi.arvalid <= 1'b1;
                        m_axi.rready  <= 1'b1;
                        r_state       <= S_RADDR;
                    end
                end

                S_DELAY: begin
                    if (r_cnt == '0) begin
                        r_pc    <= w_adv_pc;
                        r_state <= w_adv_state;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    error   <= (err_code != 2'b00);
                    err_idx <= r_pc;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase

            // Placed after the case so a same-cycle AR+R completion in RADDR
            // overrides the RADDR->RDATA transition.
            if (w_r_fire) begin
                rd_data      <= m_axi.rdata;
                rd_valid     <= 1'b1;
                m_axi.rready <= 1'b0;
                if (m_axi.rresp != 2'b00) begin
                    err_code <= C_ERR_RRESP;
                    r_state  <= S_FIN;
                end else if (r_op == C_OP_READ) begin
                    r_pc    <= w_adv_pc;
                    r_state <= w_adv_state;
                end else begin
                    r_state <= S_PCHK;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axil_cmd_seq.sv
// ============================================================================
// Module      : tb_axil_cmd_seq
// Description : Self-checking bench for axil_cmd_seq with a reactive AXI-Lite
//               slave and a command-list interpreter as reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axil_cmd_seq;

    localparam int NC = 8;
    localparam int PM = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = $clog2(NC);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_we = 1'b0;
    logic [IW-1:0] cmd_idx = '0;
    logic [2:0]    cmd_op = '0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic [DW-1:0] cmd_mask = '0;
    logic          start = 1'b0;
    logic          busy, done, error, rd_valid;
    logic [1:0]    err_code;
    logic [IW-1:0] err_idx;
    logic [DW-1:0] rd_data;

    axil_cmd_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axil_cmd_seq #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CMDS(NC),
        .POLL_MAX(PM), .DLY_WIDTH(16)
    ) dut (
        .M_AXI_aclk(clk), .M_AXI_aresetn(rst_n),
        .cmd_we(cmd_we), .cmd_idx(cmd_idx), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .start(start), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .err_idx(err_idx),
        .rd_valid(rd_valid), .rd_data(rd_data), .m_axi(axi)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Slave configuration (written by the main sequence only)
    int  aw_dly = 0, w_dly = 0, ar_dly = 0;
    bit  ar_r_same = 0;
    int  berr_at = -1, rerr_at = -1;
    bit  clr_req = 0;
    logic [31:0] rdq[$];

    // Slave / monitor state (written by the slave block only)
    int  aw_wait, w_wait, ar_wait, n_b, n_r, proto_err, nwr;
    logic [31:0] log_aw[$], log_w[$], log_ar[$], log_rdv[$];
    logic pv_aw, pr_aw, pv_w, pr_w, pv_ar, pr_ar;
    logic [31:0] pa_aw, pd_w, pa_ar;

    // Reference table and expectations
    logic [2:0]  t_op   [NC];
    logic [31:0] t_addr [NC];
    logic [31:0] t_data [NC];
    logic [31:0] t_mask [NC];
    logic [31:0] exp_aw[$], exp_wd[$], exp_ar[$], exp_rdv[$];
    logic [1:0]  exp_code;
    int          exp_idx;

    function automatic logic [31:0] rd_val(int n);
        return (n < rdq.size()) ? rdq[n] : 32'h0;
    endfunction

    // Reactive AXI-Lite slave: decides at negedge what is on the wire at the
    // next posedge, so any valid&&ready seen here is a handshake at that edge.
    always @(negedge clk) begin
        if (clr_req || !rst_n) begin
            axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
            axi.bvalid = 1'b0; axi.bresp = 2'b00;
            axi.rvalid = 1'b0; axi.rresp = 2'b00; axi.rdata = '0;
            pv_aw = 1'b0; pv_w = 1'b0; pv_ar = 1'b0;
            pr_aw = 1'b0; pr_w = 1'b0; pr_ar = 1'b0;
            if (clr_req) begin
                log_aw.delete(); log_w.delete(); log_ar.delete(); log_rdv.delete();
                n_b = 0; n_r = 0; proto_err = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0;
            end
        end else begin
            if (pv_aw && !pr_aw && (!axi.awvalid || axi.awaddr !== pa_aw)) proto_err++;
            if (pv_w  && !pr_w  && (!axi.wvalid  || axi.wdata  !== pd_w))  proto_err++;
            if (pv_ar && !pr_ar && (!axi.arvalid || axi.araddr !== pa_ar)) proto_err++;
            if (axi.wvalid && axi.wstrb !== 4'hF) proto_err++;
            if (axi.awvalid && axi.awprot !== 3'b000) proto_err++;
            if (axi.arvalid && axi.arprot !== 3'b000) proto_err++;
            if (rd_valid) log_rdv.push_back(rd_data);

            nwr = (log_aw.size() < log_w.size()) ? log_aw.size() : log_w.size();
            if (nwr > n_b) begin
                axi.bvalid = 1'b1;
                axi.bresp  = (n_b == berr_at) ? 2'b10 : 2'b00;
                if (axi.bready) n_b++;
            end else begin
                axi.bvalid = 1'b0; axi.bresp = 2'b00;
            end

            if (log_ar.size() > n_r) begin
                axi.rvalid = 1'b1;
                axi.rdata  = rd_val(n_r);
                axi.rresp  = (n_r == rerr_at) ? 2'b10 : 2'b00;
                if (axi.rready) n_r++;
            end else begin
                axi.rvalid = 1'b0; axi.rresp = 2'b00;
            end

            if (axi.awvalid) begin
                if (aw_wait >= aw_dly) begin
                    axi.awready = 1'b1; log_aw.push_back(axi.awaddr); aw_wait = 0;
                end else begin
                    axi.awready = 1'b0; aw_wait++;
                end
            end else begin
                axi.awready = 1'b0; aw_wait = 0;
            end

            if (axi.wvalid) begin
                if (w_wait >= w_dly) begin
                    axi.wready = 1'b1; log_w.push_back(axi.wdata); w_wait = 0;
                end else begin
                    axi.wready = 1'b0; w_wait++;
                end
            end else begin
                axi.wready = 1'b0; w_wait = 0;
            end

            if (axi.arvalid) begin
                if (ar_wait >= ar_dly) begin
                    axi.arready = 1'b1; log_ar.push_back(axi.araddr); ar_wait = 0;
                    if (ar_r_same && axi.rready && !axi.rvalid) begin
                        axi.rvalid = 1'b1;
                        axi.rdata  = rd_val(n_r);
                        axi.rresp  = (n_r == rerr_at) ? 2'b10 : 2'b00;
                        n_r++;
                    end
                end else begin
                    axi.arready = 1'b0; ar_wait++;
                end
            end else begin
                axi.arready = 1'b0; ar_wait = 0;
            end

            pv_aw = axi.awvalid; pr_aw = axi.awready; pa_aw = axi.awaddr;
            pv_w  = axi.wvalid;  pr_w  = axi.wready;  pd_w  = axi.wdata;
            pv_ar = axi.arvalid; pr_ar = axi.arready; pa_ar = axi.araddr;
        end
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(int idx, logic [2:0] op, logic [31:0] a, logic [31:0] d, logic [31:0] m);
        t_op[idx] = op; t_addr[idx] = a; t_data[idx] = d; t_mask[idx] = m;
        cmd_idx = idx[IW-1:0]; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
        cmd_we = 1'b1;
        tick();
        cmd_we = 1'b0;
    endtask

    task automatic clear_table();
        for (int i = 0; i < NC; i++) load(i, 3'd0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic slave_cfg(int awd, int wd, int ard, bit same, int be, int re);
        aw_dly = awd; w_dly = wd; ar_dly = ard; ar_r_same = same;
        berr_at = be; rerr_at = re;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
    endtask

    // Interprets the command list directly from the operation rules
    task automatic model();
        int  nw, nr, tries, limit;
        bit  stop, matched;
        logic [31:0] d;
        exp_aw.delete(); exp_wd.delete(); exp_ar.delete(); exp_rdv.delete();
        exp_code = 2'b00; exp_idx = 0; nw = 0; nr = 0; stop = 0;
        for (int pc = 0; pc < NC && !stop; pc++) begin
            exp_idx = pc;
            case (t_op[pc])
                3'd1: begin
                    exp_aw.push_back(t_addr[pc]); exp_wd.push_back(t_data[pc]);
                    if (nw == berr_at) begin exp_code = 2'b01; stop = 1; end
                    nw++;
                end
                3'd2, 3'd3: begin
                    matched = 0; tries = 0;
                    limit = (t_op[pc] == 3'd2) ? 1 : PM;
                    while (!stop && !matched && tries < limit) begin
                        exp_ar.push_back(t_addr[pc]);
                        d = rd_val(nr);
                        exp_rdv.push_back(d);
                        if (nr == rerr_at) begin
                            exp_code = 2'b10; stop = 1;
                        end else if (t_op[pc] == 3'd2 ||
                                     ((d & t_mask[pc]) == (t_data[pc] & t_mask[pc]))) begin
                            matched = 1;
                        end
                        nr++; tries++;
                    end
                    if (!stop && !matched) begin exp_code = 2'b11; stop = 1; end
                end
                3'd4: ;
                default: stop = 1;
            endcase
        end
    endtask

    task automatic run_seq(string t, output int lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({t, "_busy_after_start"}, busy, 1);
        lat = 0;
        while (!done && lat < 3000) begin
            tick();
            lat++;
        end
        chk({t, "_done_in_budget"}, (lat < 3000), 1);
    endtask

    task automatic compare(string t);
        chk({t, "_done"}, done, 1);
        chk({t, "_busy"}, busy, 0);
        chk({t, "_error"}, error, (exp_code != 2'b00));
        chk({t, "_err_code"}, err_code, exp_code);
        chk({t, "_err_idx"}, err_idx, exp_idx);
        chk({t, "_aw_count"}, log_aw.size(), exp_aw.size());
        chk({t, "_w_count"}, log_w.size(), exp_wd.size());
        chk({t, "_b_count"}, n_b, exp_aw.size());
        chk({t, "_ar_count"}, log_ar.size(), exp_ar.size());
        chk({t, "_rdvalid_count"}, log_rdv.size(), exp_rdv.size());
        for (int i = 0; i < exp_aw.size() && i < log_aw.size(); i++)
            chk($sformatf("%s_awaddr%0d", t, i), log_aw[i], exp_aw[i]);
        for (int i = 0; i < exp_wd.size() && i < log_w.size(); i++)
            chk($sformatf("%s_wdata%0d", t, i), log_w[i], exp_wd[i]);
        for (int i = 0; i < exp_ar.size() && i < log_ar.size(); i++)
            chk($sformatf("%s_araddr%0d", t, i), log_ar[i], exp_ar[i]);
        for (int i = 0; i < exp_rdv.size() && i < log_rdv.size(); i++)
            chk($sformatf("%s_rd_data%0d", t, i), log_rdv[i], exp_rdv[i]);
        chk({t, "_protocol"}, proto_err, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, k, n, dly;
        logic [2:0] op;

        // Reset state
        repeat (3) tick();
        chk("reset_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
        chk("reset_status", {busy, done, error, err_code, err_idx, rd_valid}, 0);
        chk("reset_rd_data", rd_data, 0);
        rst_n = 1'b1;
        tick();
        clear_table();

        // 1: three writes, zero-wait slave, 3 cycles per write
        slave_cfg(0, 0, 0, 0, -1, -1);
        load(0, 3'd1, 32'h0100, 32'h0000_0140, 32'h0);
        load(1, 3'd1, 32'h0108, 32'hC000_0000, 32'h0);
        load(2, 3'd1, 32'h0118, 32'h0800_0008, 32'h0);
        load(3, 3'd0, 32'h0, 32'h0, 32'h0);
        model();
        run_seq("t1", lat);
        compare("t1");
        chk("t1_latency", lat, 11);

        // 2: skewed AW/W readiness, both directions
        slave_cfg(5, 0, 0, 0, -1, -1);
        model();
        run_seq("t2a", lat);
        compare("t2a");
        slave_cfg(0, 5, 0, 0, -1, -1);
        run_seq("t2b", lat);
        compare("t2b");

        // 3: poll succeeds on the third read, then the next entry runs
        clear_table();
        load(0, 3'd3, 32'h0034, 32'h1, 32'h1);
        load(1, 3'd1, 32'h0040, 32'h0000_00AB, 32'h0);
        rdq = '{32'h0, 32'h0, 32'h1};
        slave_cfg(0, 0, 1, 0, -1, -1);
        model();
        run_seq("t3", lat);
        compare("t3");

        // 4: poll never matches -> timeout after POLL_MAX reads
        clear_table();
        load(0, 3'd1, 32'h0010, 32'h5, 32'h0);
        load(1, 3'd3, 32'h0034, 32'h1, 32'h1);
        rdq = '{};
        slave_cfg(0, 0, 0, 1, -1, -1);
        model();
        run_seq("t4", lat);
        compare("t4");
        chk("t4_reads", log_ar.size(), PM);

        // 5: SLVERR on the write at entry 2 stops the sequence
        clear_table();
        for (int i = 0; i < 4; i++) load(i, 3'd1, 32'h200 + 4 * i, 32'hA0 + i, 32'h0);
        slave_cfg(1, 0, 0, 0, 2, -1);
        model();
        run_seq("t5", lat);
        compare("t5");
        chk("t5_code", err_code, 2'b01);

        // Read error response
        clear_table();
        load(0, 3'd1, 32'h300, 32'h1234, 32'h0);
        load(1, 3'd2, 32'h304, 32'h0, 32'h0);
        load(2, 3'd1, 32'h308, 32'h5678, 32'h0);
        rdq = '{32'hDEAD_BEEF};
        slave_cfg(0, 0, 0, 0, -1, 0);
        model();
        run_seq("trresp", lat);
        compare("trresp");

        // DELAY timing: FETCH + (n+1) + END FETCH + FIN
        for (int i = 0; i < 2; i++) begin
            clear_table();
            dly = (i == 0) ? 0 : $urandom_range(1, 9);
            load(0, 3'd4, 32'h0, dly, 32'h0);
            slave_cfg(0, 0, 0, 0, -1, -1);
            model();
            run_seq($sformatf("tdly%0d", i), lat);
            compare($sformatf("tdly%0d", i));
            chk($sformatf("tdly%0d_latency", i), lat, dly + 4);
        end

        // Write and start in the same cycle: start is ignored
        cmd_idx = '0; cmd_op = 3'd1; cmd_addr = 32'h0; cmd_data = 32'h0;
        t_op[0] = 3'd1; t_addr[0] = 32'h0; t_data[0] = 32'h0; t_mask[0] = 32'h0;
        cmd_we = 1'b1; start = 1'b1;
        tick();
        cmd_we = 1'b0; start = 1'b0;
        tick();
        chk("we_start_collision_busy", busy, 0);

        // Randomized command lists
        for (int it = 0; it < 6; it++) begin
            clear_table();
            n = $urandom_range(2, NC);
            for (int i = 0; i < n; i++) begin
                op = 3'($urandom_range(1, 4));
                load(i, op, {$urandom_range(0, 255), 2'b00},
                     (op == 3'd3) ? 32'($urandom_range(0, 3)) :
                     (op == 3'd4) ? 32'($urandom_range(0, 5)) : $urandom,
                     32'h3);
            end
            rdq = '{};
            for (int i = 0; i < 40; i++) rdq.push_back({$urandom_range(0, 3'h7) << 2, 2'($urandom_range(0, 3))});
            slave_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1);
            model();
            run_seq($sformatf("trnd%0d", it), lat);
            compare($sformatf("trnd%0d", it));
        end

        // 6: full table of writes (implicit END), then reset during 3rd AW
        for (int i = 0; i < NC; i++) load(i, 3'd1, 32'h1000 + 8 * i, $urandom, 32'h0);
        slave_cfg(0, 0, 0, 0, -1, -1);
        model();
        run_seq("t6a", lat);
        compare("t6a");
        chk("t6a_writes", log_aw.size(), NC);

        slave_cfg(3, 0, 0, 0, -1, -1);
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!(log_aw.size() == 2 && axi.awvalid && !axi.awready) && k < 500) begin
            tick();
            k++;
        end
        chk("t6_reached_third_aw", (k < 500), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_reset_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
        chk("t6_reset_busy", busy, 0);
        tick();
        tick();
        rst_n = 1'b1;
        slave_cfg(0, 0, 0, 0, -1, -1);
        model();
        run_seq("t6b", lat);
        compare("t6b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
